// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int INSN_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } fq_entry_t;

  // Next sequential byte PC; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(2);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, insn} entries; DEPTH must be a power of 2.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fq_entry_t                din,
  output fq_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  fq_entry_t      mem [DEPTH];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PTR_W-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (PTR_W+1)'(DEPTH));
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the PC, issues one read per cycle while
// credit allows, buffers returns and hands them downstream on valid/ready.
// Optional feature macro: FETCHQ_BYPASS_EN (empty-queue returns go straight
// to the output in the cycle they arrive).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  output logic              mem_ren,
  output logic [ADDR_W-2:0] mem_raddr,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issue_pc;
  logic [ADDR_W-1:0] ret_pc;
  logic              inflight;
  logic              ret_valid;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  fq_entry_t         head;
  fq_entry_t         ret_entry;
  fq_entry_t         out_sel;

  // A redirect re-targets this cycle's read; bit 0 of the target is dropped.
  assign issue_pc  = redirect ? (redirect_pc & ~ADDR_W'(1)) : fetch_pc;
  // Queued plus in-flight entries must never exceed the FIFO depth.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign mem_ren   = rst_n & ~halt & (redirect | (occupancy < (CNT_W+1)'(DEPTH)));
  assign mem_raddr = issue_pc[ADDR_W-1:1];

  // A return landing in a redirect cycle belongs to the old stream.
  assign ret_valid = inflight & ~redirect;
  assign ret_entry = '{pc: ret_pc, insn: mem_rdata};

  // PC and in-flight tracking; redirect updates the PC even while halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      if (mem_ren)       fetch_pc <= pc_next(issue_pc);
      else if (redirect) fetch_pc <= issue_pc;
      inflight <= mem_ren;
    end
  end

  // Remember the PC of the outstanding read so it can be paired with its data.
  always_ff @(posedge clk) begin
    if (mem_ren) ret_pc <= issue_pc;
  end

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass    = ret_valid & empty;
  assign push      = ret_valid & ~full & ~(bypass & out_ready);
  assign out_valid = bypass | (~empty & ~redirect);
  assign pop       = ~empty & ~redirect & out_ready;
  assign out_sel   = empty ? ret_entry : head;
`else
  // Full is never reached by a push under the credit rule; gating is defensive.
  assign push      = ret_valid & ~full;
  assign out_valid = ~empty & ~redirect;
  assign pop       = out_valid & out_ready;
  assign out_sel   = head;
`endif

  assign out_pc   = out_valid ? out_sel.pc   : '0;
  assign out_insn = out_valid ? out_sel.insn : '0;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (ret_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, halt,
// PC wrap and asynchronous reset.
module tb_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCHQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              halt = 1'b0;
  logic              mem_ren;
  logic [ADDR_W-2:0] mem_raddr;
  logic [INSN_W-1:0] mem_rdata = '0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [INSN_W-1:0] out_insn;
  logic [ADDR_W-1:0] out_pc;

  logic              w_halt = 1'b0;
  logic              w_mem_ren;
  logic [ADDR_W-2:0] w_mem_raddr;
  logic [INSN_W-1:0] w_mem_rdata = '0;
  logic              w_redirect = 1'b0;
  logic [ADDR_W-1:0] w_redirect_pc = '0;
  logic              w_out_valid;
  logic              w_out_ready = 1'b1;
  logic [INSN_W-1:0] w_out_insn;
  logic [ADDR_W-1:0] w_out_pc;

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .halt(w_halt), .mem_ren(w_mem_ren), .mem_raddr(w_mem_raddr),
    .mem_rdata(w_mem_rdata), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_insn(w_out_insn), .out_pc(w_out_pc)
  );

  // Memory models: each word holds its own byte address, one cycle after the read.
  always @(posedge clk) if (mem_ren) mem_rdata <= {mem_raddr, 1'b0};
  always @(posedge clk) if (w_mem_ren) w_mem_rdata <= {w_mem_raddr, 1'b0};

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_pc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next expected PC.
  task automatic take();
    if (out_valid && out_ready) begin
      chk("out_pc", 32'(out_pc), 32'(exp_pc));
      chk("out_insn", 32'(out_insn), 32'(exp_pc));
      exp_pc = exp_pc + 16'd2;
    end
  endtask

  // Called right after the cycle that issued the first read of a new stream.
  task automatic restart();
    for (int j = 1; j < LAT; j++) begin
      cyc(); redirect = 1'b0; #1;
      chk("restart_gap", 32'(out_valid), 32'd0);
    end
    for (int j = 0; j < 5; j++) begin
      cyc(); redirect = 1'b0; #1;
      chk("restart_valid", 32'(out_valid), 32'd1);
      take();
    end
  endtask

  initial begin
    logic [15:0] wexp;
    logic [3:0]  occ;

    // Reset state
    repeat (3) cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_insn", 32'(out_insn), 32'd0);
    chk("rst_ren", 32'(mem_ren), 32'd0);

    // 1. Streaming after reset, plus wrap on the second instance
    cyc(); rst_n = 1'b1; #1;
    chk("first_ren", 32'(mem_ren), 32'd1);
    chk("first_raddr", 32'(mem_raddr), 32'd0);
    for (int j = 1; j < LAT; j++) begin
      cyc(); #1;
      chk("first_gap", 32'(out_valid), 32'd0);
    end
    exp_pc = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk("stream_valid", 32'(out_valid), 32'd1);
      if (i < 4) begin
        wexp = 16'hFFFC + 16'(2 * i);
        chk("wrap_valid", 32'(w_out_valid), 32'd1);
        chk("wrap_pc", 32'(w_out_pc), 32'(wexp));
      end
      take();
    end

    // 2. Backpressure: head held, credit never exceeded, then lossless drain
    for (int i = 0; i < 10; i++) begin
      cyc(); out_ready = 1'b0; #1;
      occ = 4'(u_dut.count) + 4'(u_dut.inflight);
      chk("hold_pc", 32'(out_pc), 32'(exp_pc));
      chk("occ_le_depth", 32'(occ <= 4'd4), 32'd1);
      chk("ren_when_full", 32'((occ == 4'd4) && mem_ren), 32'd0);
    end
    chk("bp_count", 32'(u_dut.count), 32'd4);
    chk("bp_ren", 32'(mem_ren), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(); out_ready = 1'b1; #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      take();
    end

    // 3. Redirect with a full FIFO
    for (int i = 0; i < 8; i++) begin
      cyc(); out_ready = 1'b0; #1;
      chk("refill_hold_pc", 32'(out_pc), 32'(exp_pc));
    end
    cyc(); out_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040; #1;
    chk("redir_full_count", 32'(u_dut.count), 32'd4);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_ren", 32'(mem_ren), 32'd1);
    chk("redir_raddr", 32'(mem_raddr), 32'h0020);
    exp_pc = 16'h0040;
    restart();

    // 4. Redirect while a return arrives; odd target is aligned down
    cyc(); redirect = 1'b1; redirect_pc = 16'h0041; #1;
    chk("redir2_inflight", 32'(u_dut.inflight), 32'd1);
    chk("redir2_valid", 32'(out_valid), 32'd0);
    chk("redir2_raddr", 32'(mem_raddr), 32'h0020);
    exp_pc = 16'h0040;
    restart();

    // 6a. Halt mid-stream: no issue, queue drains
    cyc(); halt = 1'b1; #1;
    chk("halt_ren", 32'(mem_ren), 32'd0);
    take();
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("halt_ren", 32'(mem_ren), 32'd0);
      take();
    end
    chk("halt_drained_valid", 32'(out_valid), 32'd0);
    chk("halt_drained_count", 32'(u_dut.count), 32'd0);

    // Redirect while halted: PC moves, issue stays blocked
    cyc(); redirect = 1'b1; redirect_pc = 16'h0100; #1;
    chk("halt_redir_ren", 32'(mem_ren), 32'd0);
    cyc(); redirect = 1'b0; halt = 1'b0; #1;
    chk("unhalt_ren", 32'(mem_ren), 32'd1);
    chk("unhalt_raddr", 32'(mem_raddr), 32'h0080);
    exp_pc = 16'h0100;
    restart();

    // 6b. Asynchronous reset mid-stream, then restart at RESET_PC
    cyc();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1; rst_n = 1'b0; #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ren", 32'(mem_ren), 32'd0);
    chk("async_rst_pc", 32'(out_pc), 32'd0);
    cyc();
    cyc(); rst_n = 1'b1; #1;
    chk("rerun_ren", 32'(mem_ren), 32'd1);
    chk("rerun_raddr", 32'(mem_raddr), 32'd0);
    exp_pc = 16'h0000;
    restart();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
